// File: rtl/otter_io_pkg.sv
// Shared register offsets and the timer control layout for the OTTER IOBUS responder.
package otter_io_pkg;

  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_LED   = 8'h20;
  localparam logic [7:0] OFF_CTRL  = 8'h40;
  localparam logic [7:0] OFF_PRESC = 8'h44;
  localparam logic [7:0] OFF_COUNT = 8'h48;
  localparam logic [7:0] OFF_CMP   = 8'h4C;
  localparam logic [7:0] OFF_STAT  = 8'h50;

  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // Field order puts en at bit 0 so the struct overlays the CTRL register bits.
  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } tmr_ctrl_t;

endpackage

// File: rtl/otter_io_timer.sv
// Prescaled compare timer: prescaler, COUNT, match detection and the PEND flag.
module otter_io_timer
  import otter_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  tmr_ctrl_t   i_ctrl,
  input  logic [31:0] i_presc,
  input  logic [31:0] i_cmp,
  input  logic        i_restart,
  input  logic        i_pend_clr,
  output logic [31:0] o_count,
  output logic        o_pend,
  output logic        o_pend_nxt,
  output logic        o_en_clr
);

  logic [31:0] r_pre;
  logic [31:0] r_count;
  logic        r_pend;
  logic        w_tick;
  logic        w_match;
  logic        w_unused_ie;

  assign w_tick      = i_ctrl.en && (r_pre == i_presc);
  assign w_match     = w_tick && (r_count == i_cmp);
  assign o_en_clr    = w_match && !i_ctrl.ar;
  // A match on the same edge as a clear request leaves PEND set.
  assign o_pend_nxt  = w_match || (r_pend && !i_pend_clr);
  assign o_count     = r_count;
  assign o_pend      = r_pend;
  // IRQ enable is applied at the top level, where the INTR flop lives.
  assign w_unused_ie = i_ctrl.ie;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_count <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_pend <= o_pend_nxt;
      if (i_restart) begin
        r_pre   <= '0;
        r_count <= '0;
      end else if (i_ctrl.en) begin
        if (w_tick) begin
          r_pre <= '0;
          if (w_match) begin
            if (i_ctrl.ar) r_count <= '0;
          end else begin
            r_count <= r_count + 32'd1;
          end
        end else begin
          r_pre <= r_pre + 32'd1;
        end
      end
    end
  end

endmodule

// File: rtl/otter_iobus_periph.sv
// OTTER IOBUS responder: address decode, zero-latency read mux, LED/switch/CTRL registers and the timer.
module otter_iobus_periph
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1100_0000,
  parameter int          SW_WIDTH    = 16,
  parameter int          LED_WIDTH   = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_WIDTH-1:0]  SWITCHES,
  output logic [LED_WIDTH-1:0] LEDS,
  output logic                 INTR
);

  logic [SW_WIDTH-1:0]  r_sync [SYNC_STAGES];
  logic [LED_WIDTH-1:0] r_led;
  tmr_ctrl_t            r_ctrl;
  logic [31:0]          r_presc;
  logic [31:0]          r_cmp;
  logic                 r_intr;

  logic        w_hit;
  logic [7:0]  w_off;
  logic        w_we;
  logic        w_wr_led;
  logic        w_wr_ctrl;
  logic        w_wr_presc;
  logic        w_wr_cmp;
  logic        w_wr_stat;
  tmr_ctrl_t   w_ctrl_nxt;
  logic [31:0] w_count;
  logic        w_pend;
  logic        w_pend_nxt;
  logic        w_en_clr;
  logic [31:0] w_rdata;

  assign w_hit      = (IOBUS_ADDR[31:8] == BASE_ADDR[31:8]);
  assign w_off      = IOBUS_ADDR[7:0];
  assign w_we       = IOBUS_WR && w_hit;
  assign w_wr_led   = w_we && (w_off == OFF_LED);
  assign w_wr_ctrl  = w_we && (w_off == OFF_CTRL);
  assign w_wr_presc = w_we && (w_off == OFF_PRESC);
  assign w_wr_cmp   = w_we && (w_off == OFF_CMP);
  assign w_wr_stat  = w_we && (w_off == OFF_STAT);

  // A software CTRL write overrides the one-shot EN self-clear on the same edge.
  always_comb begin
    w_ctrl_nxt = r_ctrl;
    if (w_wr_ctrl) begin
      w_ctrl_nxt = tmr_ctrl_t'(IOBUS_OUT[2:0]);
    end else if (w_en_clr) begin
      w_ctrl_nxt.en = 1'b0;
    end
  end

  otter_io_timer u_timer (
    .clk        (CLOCK),
    .rst        (RESET),
    .i_ctrl     (r_ctrl),
    .i_presc    (r_presc),
    .i_cmp      (r_cmp),
    .i_restart  (w_wr_ctrl || w_wr_cmp),
    .i_pend_clr (w_wr_stat && IOBUS_OUT[0]),
    .o_count    (w_count),
    .o_pend     (w_pend),
    .o_pend_nxt (w_pend_nxt),
    .o_en_clr   (w_en_clr)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= SWITCHES;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // INTR is computed from next-state values so it rises and falls with PEND.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_led   <= '0;
      r_ctrl  <= '0;
      r_presc <= '0;
      r_cmp   <= '0;
      r_intr  <= 1'b0;
    end else begin
      r_ctrl <= w_ctrl_nxt;
      r_intr <= w_pend_nxt && w_ctrl_nxt.ie;
      if (w_wr_led)   r_led   <= IOBUS_OUT[LED_WIDTH-1:0];
      if (w_wr_presc) r_presc <= IOBUS_OUT;
      if (w_wr_cmp)   r_cmp   <= IOBUS_OUT;
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_hit) begin
      case (w_off)
        OFF_SW:    w_rdata = 32'(r_sync[SYNC_STAGES-1]);
        OFF_LED:   w_rdata = 32'(r_led);
        OFF_CTRL:  w_rdata = {29'd0, r_ctrl};
        OFF_PRESC: w_rdata = r_presc;
        OFF_COUNT: w_rdata = w_count;
        OFF_CMP:   w_rdata = r_cmp;
        OFF_STAT:  w_rdata = {31'd0, w_pend};
        default:   w_rdata = '0;
      endcase
    end
  end

  assign IOBUS_IN = w_rdata;
  assign LEDS     = r_led;
  assign INTR     = r_intr;

endmodule

// File: tb/tb_otter_iobus_periph.sv
// Self-checking bench for otter_iobus_periph: directed scenarios plus randomized traffic against a register-level model.
module tb_otter_iobus_periph;

  localparam logic [31:0] A_SW    = 32'h1100_0000;
  localparam logic [31:0] A_LED   = 32'h1100_0020;
  localparam logic [31:0] A_CTRL  = 32'h1100_0040;
  localparam logic [31:0] A_PRESC = 32'h1100_0044;
  localparam logic [31:0] A_COUNT = 32'h1100_0048;
  localparam logic [31:0] A_CMP   = 32'h1100_004C;
  localparam logic [31:0] A_STAT  = 32'h1100_0050;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic [15:0] SWITCHES;
  logic [15:0] LEDS;
  logic        INTR;

  int n_checks;
  int n_fail;

  otter_iobus_periph #(
    .BASE_ADDR(32'h1100_0000), .SW_WIDTH(16), .LED_WIDTH(16), .SYNC_STAGES(2)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
    .IOBUS_WR(IOBUS_WR), .IOBUS_IN(IOBUS_IN), .SWITCHES(SWITCHES), .LEDS(LEDS), .INTR(INTR)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Register-level reference model, updated from the bus inputs on every rising edge.
  logic [15:0] m_led;
  logic [2:0]  m_ctrl;
  logic [31:0] m_presc, m_cmp, m_count, m_pre;
  logic        m_pend, m_intr;
  logic [15:0] m_sw [2];

  always @(posedge CLOCK) begin : model
    logic       hit, we, tick, match, p_nxt;
    logic [7:0] off;
    logic [2:0] c_nxt;
    if (RESET) begin
      m_led = 0; m_ctrl = 0; m_presc = 0; m_cmp = 0; m_count = 0; m_pre = 0;
      m_pend = 0; m_intr = 0; m_sw[0] = 0; m_sw[1] = 0;
    end else begin
      hit   = (IOBUS_ADDR[31:8] == 24'h110000);
      off   = IOBUS_ADDR[7:0];
      we    = IOBUS_WR && hit;
      tick  = m_ctrl[0] && (m_pre == m_presc);
      match = tick && (m_count == m_cmp);
      p_nxt = m_pend;
      if (we && off == 8'h50 && IOBUS_OUT[0]) p_nxt = 1'b0;
      if (match) p_nxt = 1'b1;
      c_nxt = m_ctrl;
      if (match && !m_ctrl[1]) c_nxt[0] = 1'b0;
      if (we && off == 8'h40) c_nxt = IOBUS_OUT[2:0];
      if (m_ctrl[0]) begin
        if (tick) begin
          m_pre = 0;
          if (match) begin
            if (m_ctrl[1]) m_count = 0;
          end else m_count = m_count + 1;
        end else m_pre = m_pre + 1;
      end
      if (we && (off == 8'h40 || off == 8'h4C)) begin m_pre = 0; m_count = 0; end
      if (we && off == 8'h20) m_led = IOBUS_OUT[15:0];
      if (we && off == 8'h44) m_presc = IOBUS_OUT;
      if (we && off == 8'h4C) m_cmp = IOBUS_OUT;
      m_pend = p_nxt;
      m_ctrl = c_nxt;
      m_intr = p_nxt & c_nxt[2];
      m_sw[1] = m_sw[0];
      m_sw[0] = SWITCHES;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:8] != 24'h110000) return 32'd0;
    case (a[7:0])
      8'h00: return {16'd0, m_sw[1]};
      8'h20: return {16'd0, m_led};
      8'h40: return {29'd0, m_ctrl};
      8'h44: return m_presc;
      8'h48: return m_count;
      8'h4C: return m_cmp;
      8'h50: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
    step(1);
    IOBUS_WR = 1'b0; IOBUS_OUT = 32'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    IOBUS_ADDR = a; IOBUS_WR = 1'b0;
    #1;
    d = IOBUS_IN;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    n_checks++; if (LEDS !== 16'h0) begin n_fail++; $display("FAIL reset_leds got=%h exp=0000", LEDS); end
    n_checks++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL reset_intr got=%b exp=0", INTR); end
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    bus_read(A_COUNT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=0", d); end
  endtask

  task automatic test_led();
    logic [31:0] d;
    bus_write(A_LED, 32'h0000_A5A5);
    n_checks++; if (LEDS !== 16'hA5A5) begin n_fail++; $display("FAIL led_write got=%h exp=a5a5", LEDS); end
    bus_read(A_LED, d);
    n_checks++; if (d !== 32'h0000_A5A5) begin n_fail++; $display("FAIL led_readback got=%h exp=0000a5a5", d); end
    IOBUS_ADDR = A_LED; IOBUS_OUT = 32'h0000_FFFF; IOBUS_WR = 1'b0;
    step(1);
    n_checks++; if (LEDS !== 16'hA5A5) begin n_fail++; $display("FAIL led_no_wr got=%h exp=a5a5", LEDS); end
  endtask

  task automatic test_switch_sync();
    logic [31:0] d;
    SWITCHES = 16'h1234;
    bus_read(A_SW, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_edge0 got=%h exp=0", d); end
    step(1); bus_read(A_SW, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL sw_edge1 got=%h exp=0", d); end
    step(1); bus_read(A_SW, d);
    n_checks++; if (d !== 32'h0000_1234) begin n_fail++; $display("FAIL sw_edge2 got=%h exp=00001234", d); end
  endtask

  task automatic test_auto_reload();
    logic [31:0] d;
    bus_write(A_PRESC, 32'd3);
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'h7);
    step(23);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h0 || INTR !== 1'b0) begin n_fail++; $display("FAIL ar_early stat=%h intr=%b exp=0/0", d, INTR); end
    step(1);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h1 || INTR !== 1'b1) begin n_fail++; $display("FAIL ar_match stat=%h intr=%b exp=1/1", d, INTR); end
    bus_read(A_COUNT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ar_count got=%h exp=0", d); end
    bus_write(A_STAT, 32'h1);
    n_checks++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL ar_clear intr=%b exp=0", INTR); end
    step(22);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ar_second_early got=%h exp=0", d); end
    step(1);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h1 || INTR !== 1'b1) begin n_fail++; $display("FAIL ar_second stat=%h intr=%b exp=1/1", d, INTR); end
  endtask

  task automatic test_oneshot_race();
    logic [31:0] d;
    bus_write(A_CTRL, 32'h0);
    bus_write(A_STAT, 32'h1);
    bus_write(A_PRESC, 32'd1);
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'h5);
    step(7);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL os_early got=%h exp=0", d); end
    bus_write(A_STAT, 32'h1);
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h1 || INTR !== 1'b1) begin n_fail++; $display("FAIL os_race stat=%h intr=%b exp=1/1", d, INTR); end
    bus_read(A_CTRL, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL os_en_clr got=%h exp=4", d); end
    step(5);
    bus_read(A_COUNT, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL os_hold got=%h exp=3", d); end
    bus_write(A_STAT, 32'h1);
    n_checks++; if (INTR !== 1'b0) begin n_fail++; $display("FAIL os_clear intr=%b exp=0", INTR); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    logic [15:0] led0;
    bus_read(32'h1100_0010, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dec_unmapped got=%h exp=0", d); end
    bus_read(32'h1100_0021, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dec_misaligned got=%h exp=0", d); end
    led0 = LEDS;
    bus_write(32'h1200_0020, 32'h0000_FFFF);
    n_checks++; if (LEDS !== led0) begin n_fail++; $display("FAIL dec_miss_write got=%h exp=%h", LEDS, led0); end
    bus_write(A_PRESC, 32'd0);
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'h7);
    step(3);
    n_checks++; if (INTR !== 1'b1) begin n_fail++; $display("FAIL dec_pre_reset intr=%b exp=1", INTR); end
    step(2);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    bus_read(A_COUNT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_count got=%h exp=0", d); end
    bus_read(A_STAT, d);
    n_checks++; if (d !== 32'h0 || INTR !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pend stat=%h intr=%b exp=0/0", d, INTR); end
  endtask

  task automatic test_random();
    logic [7:0]  offs [10];
    logic [31:0] a, d, exp_rd;
    offs = '{8'h00, 8'h20, 8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h10, 8'h21, 8'h4D};
    for (int i = 0; i < 600; i++) begin
      a = {24'h110000, offs[$urandom_range(0, 9)]};
      if ($urandom_range(0, 7) == 0) a = $urandom;
      if ($urandom_range(0, 7) == 0) a = {24'h120000, a[7:0]};
      d = $urandom;
      if (a[7:0] == 8'h44) d = d & 32'h3;
      if (a[7:0] == 8'h4C) d = d & 32'h7;
      RESET      = ($urandom_range(0, 99) == 0);
      SWITCHES   = $urandom;
      IOBUS_ADDR = a;
      IOBUS_OUT  = d;
      IOBUS_WR   = ($urandom_range(0, 3) == 0);
      #1;
      exp_rd = model_read(a);
      n_checks++; if (IOBUS_IN !== exp_rd) begin n_fail++; $display("FAIL rnd_read i=%0d addr=%h got=%h exp=%h", i, a, IOBUS_IN, exp_rd); end
      n_checks++; if (LEDS !== m_led) begin n_fail++; $display("FAIL rnd_leds i=%0d got=%h exp=%h", i, LEDS, m_led); end
      n_checks++; if (INTR !== m_intr) begin n_fail++; $display("FAIL rnd_intr i=%0d got=%b exp=%b", i, INTR, m_intr); end
      step(1);
    end
    RESET = 1'b0; IOBUS_WR = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    RESET      = 1'b1;
    IOBUS_ADDR = 32'd0;
    IOBUS_OUT  = 32'd0;
    IOBUS_WR   = 1'b0;
    SWITCHES   = 16'd0;
    step(1);
    test_reset();
    test_led();
    test_switch_sync();
    test_auto_reload();
    test_oneshot_race();
    test_decode();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
